a2bus_event_fifo: RTL
=====================

# a2bus_event_fifo

Downstream consumer of the Apple II bus sampler. On each `data_in_strobe` it takes the latched address, data and R/W, applies an inclusive address-window filter, and queues matching bus cycles in a show-ahead FIFO. Logic-side clients (soft CPU, mailbox, video shadow) drain it with a valid/ready handshake. Overflow is detected, counted and flagged; the bus is never stalled.

## Interface

Parameters:
- `DEPTH`, 16: FIFO entries; power of two, range 4..256.
- `ADDR_LO`, 16'hC080: inclusive low bound of the capture window.
- `ADDR_HI`, 16'hC0FF: inclusive high bound of the capture window.
- `CAPTURE_READS`, 0: 1 queues read cycles as well as writes; 0 queues writes only.

Ports:
- `clk_logic_i`  in  1  sole clock; all logic runs on its rising edge.
- `system_reset_n_i`  in  1  asynchronous, active-low reset.
- `bus_strobe_i`  in  1  one-cycle pulse; bus fields below are valid on this cycle.
- `bus_addr_i`  in  16  latched bus address.
- `bus_data_i`  in  8  latched bus data.
- `bus_rw_n_i`  in  1  1 = read, 0 = write.
- `flush_i`  in  1  synchronous clear of FIFO contents.
- `clear_ovf_i`  in  1  synchronous clear of `ovf_o` and `drop_cnt_o`.
- `evt_valid_o`  out  1  the head entry is presented on the event outputs.
- `evt_ready_i`  in  1  consumer accepts the head entry.
- `evt_addr_o`  out  16  head entry address.
- `evt_data_o`  out  8  head entry data.
- `evt_rw_n_o`  out  1  head entry R/W.
- `level_o`  out  $clog2(DEPTH)+1  current occupancy.
- `ovf_o`  out  1  sticky overflow flag.
- `drop_cnt_o`  out  8  count of dropped events; saturates at 255.

## Operation

- **Stage 1 (capture).** On `bus_strobe_i`, register `{addr, data, rw_n}` together with `hit`.
  - `hit` = (ADDR_LO ≤ addr ≤ ADDR_HI) && (!rw_n || CAPTURE_READS).
  - Comparisons are unsigned, 16-bit.
  - The stage-1 valid bit (`s1_v`) is set only for a strobe that hits. It clears on the next cycle unless a new strobe arrives.
- **Stage 2 (push).** If `s1_v` is set:
  - Write the entry at `wr_ptr` if `level < DEPTH` or a pop occurs in the same cycle.
  - Otherwise drop the entry, set `ovf_o`, and increment `drop_cnt_o` (saturating).
- **Pop.** Occurs when `evt_valid_o && evt_ready_i`; `rd_ptr` advances.
- **Event outputs.** Combinational read of the entry at `rd_ptr`. `evt_valid_o` = (level ≠ 0).
- **Pointers.** Width $clog2(DEPTH) and wrap naturally. `level` is a separate counter: +1 on push, −1 on pop, unchanged when both or neither occur.
- **Output stability.** While `evt_valid_o` is high and `evt_ready_i` is low, all event outputs hold stable.
- **`flush_i`.** Zeroes both pointers, `level` and `s1_v` that cycle. It takes priority over a same-cycle push or pop. It does not touch `ovf_o` or `drop_cnt_o`.
- **`clear_ovf_i`.** Zeroes `ovf_o` and `drop_cnt_o`. If a drop occurs in the same cycle, the drop wins: `ovf_o` = 1 and `drop_cnt_o` = 1.
- **Reset values.** `evt_valid_o` 0, `level_o` 0, `ovf_o` 0, `drop_cnt_o` 0, pointers 0, `s1_v` 0. Event data outputs are don't-care while not valid.
- **Reset mid-operation.** The queue empties immediately and asynchronously. Storage RAM is not cleared.

## Timing

- **Latency.** A strobe at edge N produces the push at edge N+1, so `evt_valid_o` is high after edge N+1 (2 edges strobe-to-visible when the FIFO is empty).
- **Throughput.** One push per cycle, so back-to-back strobes are legal. Bus strobes actually arrive roughly every 52 cycles.
- **Pop.** The next entry is visible one cycle after the popping edge. Zero-bubble continuous drain is supported.
- **Full FIFO with simultaneous push and pop.** Both occur, level stays at DEPTH, no drop.
- **Empty FIFO.** A push and a ready in the same cycle do not pop, because valid is still 0. The entry becomes visible the next cycle.
- **Ready.** `evt_ready_i` may be held high permanently.

## Structure

- **Package `a2bus_event_pkg`:**
  - `typedef struct packed { logic [15:0] addr; logic [7:0] data; logic rw_n; } a2bus_event_t`
  - `localparam EVENT_W = 25`
  - `localparam DROP_CNT_MAX = 8'hFF`
- **Sub-module `a2bus_event_ram`:** DEPTH × EVENT_W distributed RAM with one synchronous write port and an asynchronous read port. No reset.
- **Top-level wiring.** The filter, pointers, level and overflow logic live in `a2bus_event_fifo`. At the top level, the `bus_*` ports connect to the bus interface's `data_in_strobe`, `addr`, `data` and `rw_n`.

## Test plan

- **Write in window.** Write $C0A5 ← $3C, ready low. Expect valid high 2 edges after the strobe, outputs $C0A5/$3C/0, level 1. Raise ready: one pop, level 0.
- **Filtering.** Write $C07F, write $C100, and read $C080 (CAPTURE_READS=0). Expect none queued and level 0. With CAPTURE_READS=1, the read of $C080 is queued.
- **Overflow.** DEPTH=16, ready low, 18 hitting writes. Expect level 16, `ovf_o` 1, `drop_cnt_o` 2. Drain order must equal entries 1..16. `clear_ovf_i` then gives `ovf_o` 0 and count 0.
- **Full with simultaneous push/pop.** Full FIFO, ready high on the same cycle as a stage-2 push. Expect level stays 16, no drop, and the head advances by one.
- **Flush.** Queue 5 entries, assert `flush_i` on a cycle that also carries a push. Expect level 0 and valid 0 next cycle, while `ovf_o` and `drop_cnt_o` are unchanged.
- **Reset mid-operation.** Queue 3 entries, pulse `system_reset_n_i` low between clock edges. Expect valid and level 0 immediately, with no clock required. A subsequent write to $C0FF appears with correct data.

Source files
------------

// File: rtl/a2bus_event_pkg.sv
// Shared types and constants for the Apple II bus event capture FIFO.
package a2bus_event_pkg;

  localparam int          EVENT_W      = 25;
  localparam logic [7:0]  DROP_CNT_MAX = 8'hFF;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
    logic        rw_n;
  } a2bus_event_t;

  // Inclusive unsigned window match; reads only count when enabled.
  function automatic logic addr_hit(input logic [15:0] addr, input logic [15:0] lo,
                                    input logic [15:0] hi, input logic rw_n,
                                    input logic cap_reads);
    return (addr >= lo) && (addr <= hi) && (!rw_n || cap_reads);
  endfunction

endpackage

// File: rtl/a2bus_event_ram.sv
// DEPTH x EVENT_W distributed RAM: synchronous write, asynchronous read, no reset.
module a2bus_event_ram
  import a2bus_event_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               clk_i,
  input  logic               we_i,
  input  logic [AW-1:0]      waddr_i,
  input  logic [EVENT_W-1:0] wdata_i,
  input  logic [AW-1:0]      raddr_i,
  output logic [EVENT_W-1:0] rdata_o
);

  logic [EVENT_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/a2bus_event_fifo.sv
// Filters latched Apple II bus cycles by address window and queues hits in a
// show-ahead FIFO; overflow drops new entries and is counted, never stalling the bus.
module a2bus_event_fifo
  import a2bus_event_pkg::*;
#(
  parameter int          DEPTH         = 16,
  parameter logic [15:0] ADDR_LO       = 16'hC080,
  parameter logic [15:0] ADDR_HI       = 16'hC0FF,
  parameter bit          CAPTURE_READS = 1'b0
) (
  input  logic                     clk_logic_i,
  input  logic                     system_reset_n_i,
  input  logic                     bus_strobe_i,
  input  logic [15:0]              bus_addr_i,
  input  logic [7:0]               bus_data_i,
  input  logic                     bus_rw_n_i,
  input  logic                     flush_i,
  input  logic                     clear_ovf_i,
  output logic                     evt_valid_o,
  input  logic                     evt_ready_i,
  output logic [15:0]              evt_addr_o,
  output logic [7:0]               evt_data_o,
  output logic                     evt_rw_n_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     ovf_o,
  output logic [7:0]               drop_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  a2bus_event_t  s1_q;
  logic          s1_v_q, s1_v_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    drop_cnt_q, drop_cnt_d;

  logic          hit, pop, room, push, drop;
  a2bus_event_t  head;
  logic [EVENT_W-1:0] rd_word;

  assign hit = addr_hit(bus_addr_i, ADDR_LO, ADDR_HI, bus_rw_n_i, CAPTURE_READS);

  // A pop frees a slot in the same cycle, so a full FIFO can still accept.
  assign evt_valid_o = (level_q != '0);
  assign pop  = evt_valid_o && evt_ready_i;
  assign room = (level_q != FULL_LVL) || pop;
  assign push = s1_v_q && room && !flush_i;
  assign drop = s1_v_q && !room && !flush_i;

  always_comb begin
    s1_v_d     = bus_strobe_i && hit && !flush_i;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    ovf_d      = ovf_q;
    drop_cnt_d = drop_cnt_q;

    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end

    // A drop in the same cycle as a clear restarts the count at one.
    if (drop) begin
      ovf_d      = 1'b1;
      drop_cnt_d = clear_ovf_i ? 8'd1 :
                   (drop_cnt_q == DROP_CNT_MAX) ? DROP_CNT_MAX : drop_cnt_q + 8'd1;
    end else if (clear_ovf_i) begin
      ovf_d      = 1'b0;
      drop_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_logic_i or negedge system_reset_n_i) begin
    if (!system_reset_n_i) begin
      s1_v_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      s1_v_q     <= s1_v_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      ovf_q      <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Capture payload needs no reset; s1_v_q qualifies it.
  always_ff @(posedge clk_logic_i) begin
    if (bus_strobe_i) s1_q <= '{addr: bus_addr_i, data: bus_data_i, rw_n: bus_rw_n_i};
  end

  a2bus_event_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk_i   (clk_logic_i),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (s1_q),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_word)
  );

  assign head       = a2bus_event_t'(rd_word);
  assign evt_addr_o = head.addr;
  assign evt_data_o = head.data;
  assign evt_rw_n_o = head.rw_n;
  assign level_o    = level_q;
  assign ovf_o      = ovf_q;
  assign drop_cnt_o = drop_cnt_q;

endmodule
